// File: rtl/draw_pkg.sv
// draw_pkg: shared drawing FSM states, colour palette and screen geometry
package draw_pkg;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLOT,
        ST_DONE
    } draw_state_e;
    localparam logic [2:0] PATH    = 3'b111;
    localparam logic [2:0] WALL    = 3'b000;
    localparam logic [2:0] PLAYER  = 3'b100;
    localparam logic [2:0] SPECIAL = 3'b010;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
endpackage

// File: rtl/box_offset_counter.sv
// box_offset_counter: raster-order 2-D offset counter with clear, enable and last-pixel flag
// Ports: clock/resetn, clr (zero both offsets), en (advance one pixel),
//        col/row (current offset), col_nxt/row_nxt (offset after advancing), last (at final pixel)
module box_offset_counter #(
    parameter int BOX_SIZE = 4,
    parameter int OFF_W = $clog2(BOX_SIZE)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clr,
    input  logic             en,
    output logic [OFF_W-1:0] col,
    output logic [OFF_W-1:0] row,
    output logic [OFF_W-1:0] col_nxt,
    output logic [OFF_W-1:0] row_nxt,
    output logic             last
);
    localparam logic [OFF_W-1:0] MAX = OFF_W'(BOX_SIZE - 1);
    logic [OFF_W-1:0] col_q, col_d, row_q, row_d;
    // BOX_SIZE is a power of two, so the column wraps by natural overflow
    always_comb begin
        col_nxt = col_q + 1'b1;
        row_nxt = (col_q == MAX) ? row_q + 1'b1 : row_q;
        col_d   = clr ? '0 : en ? col_nxt : col_q;
        row_d   = clr ? '0 : en ? row_nxt : row_q;
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
    assign col  = col_q;
    assign row  = row_q;
    assign last = (col_q == MAX) && (row_q == MAX);
endmodule

// File: rtl/box_draw_engine.sv
// box_draw_engine: draws/erases the player box on request and holds a done flag until released
// Ports: clock/resetn, drawBox/eraseBox (level requests), boxX/boxY (box origin),
//        vgaX/vgaY/vgaColour/vgaPlot (VGA plot port), doneDraw/doneErase (completion flags)
module box_draw_engine
    import draw_pkg::*;
#(
    parameter int         BOX_SIZE     = 4,
    parameter int         X_WIDTH      = 8,
    parameter int         Y_WIDTH      = 7,
    parameter int         SCREEN_W     = draw_pkg::SCREEN_W,
    parameter int         SCREEN_H     = draw_pkg::SCREEN_H,
    parameter logic [2:0] DRAW_COLOUR  = PLAYER,
    parameter logic [2:0] ERASE_COLOUR = PATH
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               drawBox,
    input  logic               eraseBox,
    input  logic [X_WIDTH-1:0] boxX,
    input  logic [Y_WIDTH-1:0] boxY,
    output logic [X_WIDTH-1:0] vgaX,
    output logic [Y_WIDTH-1:0] vgaY,
    output logic [2:0]         vgaColour,
    output logic               vgaPlot,
    output logic               doneDraw,
    output logic               doneErase
);
    localparam int OFF_W = $clog2(BOX_SIZE);
    draw_state_e        state_q, state_d;
    logic [X_WIDTH-1:0] x_lat_q, x_lat_d, vga_x_q, vga_x_d;
    logic [Y_WIDTH-1:0] y_lat_q, y_lat_d, vga_y_q, vga_y_d;
    logic [2:0]         colour_q, colour_d;
    logic               erase_q, erase_d, plot_q, plot_d;
    logic               done_draw_q, done_draw_d, done_erase_q, done_erase_d;
    logic               cnt_clr, cnt_en, last, idle, req, pix_ok;
    logic [OFF_W-1:0]   col, row, col_nxt, row_nxt, off_x, off_y;
    logic [X_WIDTH-1:0] base_x;
    logic [Y_WIDTH-1:0] base_y;
    logic [X_WIDTH:0]   sum_x;
    logic [Y_WIDTH:0]   sum_y;

    box_offset_counter #(.BOX_SIZE(BOX_SIZE), .OFF_W(OFF_W)) u_cnt (
        .clock   (clock),
        .resetn  (resetn),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .col     (col),
        .row     (row),
        .col_nxt (col_nxt),
        .row_nxt (row_nxt),
        .last    (last)
    );

    // Pixel about to be registered: the origin itself on acceptance, otherwise
    // the latched origin plus the counter's next offset. The extra sum bit is the carry.
    always_comb begin
        idle   = (state_q == ST_IDLE);
        base_x = idle ? boxX : x_lat_q;
        base_y = idle ? boxY : y_lat_q;
        off_x  = idle ? '0 : col_nxt;
        off_y  = idle ? '0 : row_nxt;
        sum_x  = (X_WIDTH+1)'(base_x) + (X_WIDTH+1)'(off_x);
        sum_y  = (Y_WIDTH+1)'(base_y) + (Y_WIDTH+1)'(off_y);
        pix_ok = !sum_x[X_WIDTH] && !sum_y[Y_WIDTH]
                 && (sum_x < (X_WIDTH+1)'(SCREEN_W)) && (sum_y < (Y_WIDTH+1)'(SCREEN_H));
        req    = erase_q ? eraseBox : drawBox;
    end

    always_comb begin
        state_d      = state_q;
        x_lat_d      = x_lat_q;
        y_lat_d      = y_lat_q;
        erase_d      = erase_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        colour_d     = colour_q;
        plot_d       = 1'b0;
        done_draw_d  = done_draw_q;
        done_erase_d = done_erase_q;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        case (state_q)
            ST_IDLE: if (eraseBox || drawBox) begin
                state_d  = ST_PLOT;
                x_lat_d  = boxX;
                y_lat_d  = boxY;
                erase_d  = eraseBox;
                cnt_clr  = 1'b1;
                vga_x_d  = sum_x[X_WIDTH-1:0];
                vga_y_d  = sum_y[Y_WIDTH-1:0];
                colour_d = eraseBox ? ERASE_COLOUR : DRAW_COLOUR;
                plot_d   = pix_ok;
            end
            ST_PLOT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (last) begin
                    state_d      = ST_DONE;
                    done_draw_d  = !erase_q;
                    done_erase_d = erase_q;
                end else begin
                    cnt_en  = 1'b1;
                    vga_x_d = sum_x[X_WIDTH-1:0];
                    vga_y_d = sum_y[Y_WIDTH-1:0];
                    plot_d  = pix_ok;
                end
            end
            ST_DONE: if (!req) begin
                state_d      = ST_IDLE;
                done_draw_d  = 1'b0;
                done_erase_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            x_lat_q      <= '0;
            y_lat_q      <= '0;
            erase_q      <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            done_draw_q  <= 1'b0;
            done_erase_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_lat_q      <= x_lat_d;
            y_lat_q      <= y_lat_d;
            erase_q      <= erase_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            done_draw_q  <= done_draw_d;
            done_erase_q <= done_erase_d;
        end
    end

    assign vgaX      = vga_x_q;
    assign vgaY      = vga_y_q;
    assign vgaColour = colour_q;
    assign vgaPlot   = plot_q;
    assign doneDraw  = done_draw_q;
    assign doneErase = done_erase_q;
endmodule

// File: tb/tb_box_draw_engine.sv
// tb_box_draw_engine: table-driven directed bench for box_draw_engine
module tb_box_draw_engine;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       drawBox = 1'b0;
    logic       eraseBox = 1'b0;
    logic [7:0] boxX = '0;
    logic [6:0] boxY = '0;
    logic [7:0] vgaX;
    logic [6:0] vgaY;
    logic [2:0] vgaColour;
    logic       vgaPlot, doneDraw, doneErase;
    int vectors = 0;
    int errors = 0;

    typedef struct {
        logic        drw;
        logic        ers;
        logic [7:0]  bx;
        logic [6:0]  by;
        logic [2:0]  col;
        logic [15:0] mask;
        logic        dd;
        logic        de;
    } vec_t;
    vec_t tbl[5];

    box_draw_engine dut (
        .clock     (clock),
        .resetn    (resetn),
        .drawBox   (drawBox),
        .eraseBox  (eraseBox),
        .boxX      (boxX),
        .boxY      (boxY),
        .vgaX      (vgaX),
        .vgaY      (vgaY),
        .vgaColour (vgaColour),
        .vgaPlot   (vgaPlot),
        .doneDraw  (doneDraw),
        .doneErase (doneErase)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " plot"}, 32'(vgaPlot), 0);
        chk({tag, " doneDraw"}, 32'(doneDraw), 0);
        chk({tag, " doneErase"}, 32'(doneErase), 0);
    endtask

    // Called on a falling edge: raise the request, check all 16 pixels, the done
    // flag and its hold, then release and check the flag clears.
    task automatic run_pass(input vec_t v, input int npix);
        logic [7:0] ex;
        logic [6:0] ey;
        drawBox  = v.drw;
        eraseBox = v.ers;
        boxX     = v.bx;
        boxY     = v.by;
        for (int k = 0; k < npix; k++) begin
            @(negedge clock);
            ex = v.bx + 8'(k % 4);
            ey = v.by + 7'(k / 4);
            chk($sformatf("px%0d x", k), 32'(vgaX), 32'(ex));
            chk($sformatf("px%0d y", k), 32'(vgaY), 32'(ey));
            chk($sformatf("px%0d colour", k), 32'(vgaColour), 32'(v.col));
            chk($sformatf("px%0d plot", k), 32'(vgaPlot), 32'(v.mask[k]));
            chk($sformatf("px%0d doneDraw", k), 32'(doneDraw), 0);
            chk($sformatf("px%0d doneErase", k), 32'(doneErase), 0);
        end
        if (npix < 16) return;
        for (int h = 0; h < 4; h++) begin
            @(negedge clock);
            chk($sformatf("hold%0d plot", h), 32'(vgaPlot), 0);
            chk($sformatf("hold%0d doneDraw", h), 32'(doneDraw), 32'(v.dd));
            chk($sformatf("hold%0d doneErase", h), 32'(doneErase), 32'(v.de));
            if (v.drw && !v.ers) eraseBox = (h == 1);
        end
        drawBox  = 1'b0;
        eraseBox = 1'b0;
        @(negedge clock);
        chk_quiet("release");
        @(negedge clock);
        chk_quiet("gap");
    endtask

    initial begin
        tbl[0] = '{drw: 1, ers: 0, bx: 8'd20,  by: 7'd10,  col: 3'b100, mask: 16'hFFFF, dd: 1, de: 0};
        tbl[1] = '{drw: 1, ers: 1, bx: 8'd0,   by: 7'd0,   col: 3'b111, mask: 16'hFFFF, dd: 0, de: 1};
        tbl[2] = '{drw: 1, ers: 0, bx: 8'd158, by: 7'd118, col: 3'b100, mask: 16'h0033, dd: 1, de: 0};
        tbl[3] = '{drw: 0, ers: 1, bx: 8'd254, by: 7'd5,   col: 3'b111, mask: 16'h0000, dd: 0, de: 1};
        tbl[4] = '{drw: 0, ers: 1, bx: 8'd100, by: 7'd126, col: 3'b111, mask: 16'h0000, dd: 0, de: 1};

        #2;
        chk("reset x", 32'(vgaX), 0);
        chk("reset y", 32'(vgaY), 0);
        chk("reset colour", 32'(vgaColour), 0);
        chk_quiet("reset");
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 5; i++) run_pass(tbl[i], 16);

        // Abort after pixel 5, then a fresh erase two cycles later
        run_pass('{drw: 1, ers: 0, bx: 8'd40, by: 7'd20, col: 3'b100, mask: 16'hFFFF, dd: 1, de: 0}, 6);
        drawBox = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            chk_quiet($sformatf("abort%0d", j));
        end
        run_pass('{drw: 0, ers: 1, bx: 8'd40, by: 7'd20, col: 3'b111, mask: 16'hFFFF, dd: 0, de: 1}, 16);

        // Reset asserted at pixel 8 clears outputs without waiting for a clock
        run_pass(tbl[0], 9);
        #1;
        resetn = 1'b0;
        #1;
        chk("rst x", 32'(vgaX), 0);
        chk("rst y", 32'(vgaY), 0);
        chk("rst colour", 32'(vgaColour), 0);
        chk_quiet("rst");
        @(negedge clock);
        chk_quiet("rst held");
        resetn = 1'b1;
        run_pass(tbl[0], 16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
